// File: rtl/spi_bridge_if.sv
// Decoder-side bus of the SPI bridge: received byte with its strobe, and the
// response byte the decoder hands back for the next SPI byte slot.
interface spi_bridge_if;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output byte_sync, output data_in, input data_out);
  modport slave  (input byte_sync, input data_in, output data_out);
endinterface

// File: rtl/spi_bridge.sv
// SPI mode-0 slave front-end. Synchronises sclk/cs_n/mosi into clk, shifts
// MOSI into bytes (one-cycle byte_sync per byte), and shifts the decoder's
// response out on MISO during the following byte.
// Optional macro SPI_BRIDGE_MISO_TRISTATE_EN: release miso (1'bz) while idle.
//
// state  | meaning
// IDLE   | no frame; bit counter and rx cleared, sclk edges ignored
// ACTIVE | cs_n low after a synchronised falling edge; shifting bits
module spi_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  spi_bridge_if.master bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_d, cs_d;
  logic sclk_s, cs_s, mosi_s;
  logic rise, fall, sel_start, active;
  logic [2:0] bit_cnt;
  logic [7:0] rx, tx;
  logic start_q;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign rise      = sclk_s & ~sclk_d;
  assign fall      = ~sclk_s & sclk_d;
  assign sel_start = ~cs_s & cs_d;

  // Shifting is only allowed while the frame is open; a raised cs_n wins at once.
  assign active = (state == ACTIVE) && !cs_s;

  // Pin synchronisers plus one extra sample of sclk/cs_n for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Frame next-state: open on a synchronised cs_n fall, close whenever cs_n is high.
  always_comb begin
    state_nxt = state;
    if (cs_s)
      state_nxt = IDLE;
    else if (state == IDLE && sel_start)
      state_nxt = ACTIVE;
  end

  // Receive path: shift on sclk rise; the 8th bit publishes the byte and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx            <= '0;
      bit_cnt       <= '0;
      bus.byte_sync <= 1'b0;
      bus.data_in   <= '0;
    end else begin
      bus.byte_sync <= active && rise && (bit_cnt == 3'd7);
      if (!active) begin
        rx      <= '0;
        bit_cnt <= '0;
      end else if (rise) begin
        rx      <= {rx[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7)
          bus.data_in <= {rx[6:0], mosi_s};
      end
    end
  end

  // Transmit path: reload after frame start and after each byte (load beats a
  // shift); skipping the shift on the post-byte fall keeps the new MSB on miso.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= (state == IDLE) && sel_start;
      if (start_q || bus.byte_sync)
        tx <= bus.data_out;
      else if (active && fall && (bit_cnt != 3'd0))
        tx <= {tx[6:0], 1'b0};
    end
  end

  // MISO driver: MSB of tx during a frame, parked otherwise.
  always_comb begin
`ifdef SPI_BRIDGE_MISO_TRISTATE_EN
    miso = (state == ACTIVE) ? tx[7] : 1'bz;
`else
    miso = (state == ACTIVE) ? tx[7] : 1'b0;
`endif
  end

endmodule

// File: doc/spi_bridge.md
# spi_bridge

SPI slave front-end for the PWM generator's register interface. It synchronises the external SPI pins (mode 0, MSB first) into the `clk` domain and deserialises MOSI into bytes. Each completed byte is presented to the instruction decoder on `data_in` with a one-cycle `byte_sync` strobe. The decoder's `data_out` is serialised back on MISO during the following byte.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of the `sclk`/`cs_n`/`mosi` synchronisers. Legal range is 2–3.

Ports:
- `clk`  in  1  peripheral clock; all logic is on its rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `sclk`  in  1  SPI clock from master; asynchronous to `clk`; idles low
- `cs_n`  in  1  SPI chip select, active low; asynchronous
- `mosi`  in  1  SPI master-out data; asynchronous
- `miso`  out  1  SPI master-in data
- `byte_sync`  out  1  one-`clk` pulse when a full byte has been received
- `data_in`  out  8  last received byte; held until the next byte completes
- `data_out`  in  8  byte to transmit in the next SPI byte slot

## Operation
- Synchronisers: `sclk`, `cs_n` and `mosi` each pass through `SYNC_STAGES` flops.
  - Edge detect compares the last synchronised sample with the previous one, giving `rise` and `fall` for `sclk`, and `sel_start` for the `cs_n` falling edge.
- Frame state is `IDLE` or `ACTIVE`.
  - `IDLE` → `ACTIVE` on `sel_start`.
  - Any state → `IDLE` whenever synchronised `cs_n` is 1.
  - In `IDLE`: `bit_cnt`=0, the receive shift register is cleared, `sclk` edges are ignored, and no `byte_sync` is produced.
- Receive, on `rise` in `ACTIVE`:
  - `rx <= {rx[6:0], mosi_s}`; `bit_cnt <= bit_cnt + 1`, 3-bit, wraps 7→0.
  - When the increment wraps (the 8th bit), the next cycle drives `data_in <= {rx[6:0], mosi_s}` and `byte_sync`=1 for exactly one cycle.
- Transmit:
  - `tx` is an 8-bit shift register and `miso` = `tx[7]` while `ACTIVE`.
  - `tx` loads from `data_out` in the cycle after `sel_start`, and in the cycle after `byte_sync`. The second load catches the decoder's combinational response to the byte.
  - On `fall` in `ACTIVE` with `bit_cnt != 0`: `tx <= {tx[6:0], 1'b0}`.
  - On `fall` with `bit_cnt == 0` (the falling edge after a completed byte) there is no shift, so the freshly loaded MSB stays on `miso`.
- Aborted byte: if `cs_n` rises with `bit_cnt != 0`, the partial byte is discarded. There is no `byte_sync`, and `data_in` keeps its old value.
- Simultaneous events: a load and a `fall` in the same cycle resolve as the load winning. `rise` and `fall` cannot coincide.

## Timing
- Reset values:
  - Outputs: `miso`=0, `byte_sync`=0, `data_in`=8'h00.
  - Internal: state `IDLE`, `bit_cnt`=0, `rx`=0, `tx`=0.
  - Synchroniser flops reset to `sclk`=0, `cs_n`=1, `mosi`=0.
- Reset asserted mid-frame returns everything to reset values immediately. After release, a new `cs_n` falling edge is required to start a frame.
- Latency from the 8th `sclk` rising pin edge to `byte_sync`: `SYNC_STAGES`+2 `clk` cycles.
- `tx` reload happens `byte_sync`+1 cycle.
- Constraint: `clk` ≥ 8× `sclk`, and each `sclk` half-period ≥ `SYNC_STAGES`+3 `clk` cycles. This guarantees the reload precedes the next `fall`.
- `cs_n` setup to the first `sclk` rise is ≥ `SYNC_STAGES`+2 `clk` cycles.
- The first byte of a frame transmits whatever `data_out` holds at frame start (normally 8'h00).

## Configuration
- `SPI_BRIDGE_MISO_TRISTATE_EN`
  - Defined: `miso` is 1'bz while state is `IDLE` or during reset, and `tx[7]` while `ACTIVE`. This supports a shared MISO line.
  - Undefined: `miso` is driven 0 in `IDLE` and during reset.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 with pins toggling. Required: `byte_sync`=0, `data_in`=8'h00, `miso`=0, or Z with the macro defined.
- Single write byte: `cs_n` low, shift 8'hA5 MSB-first at `clk`/10. Required: exactly one `byte_sync` pulse, `data_in`=8'hA5 at that pulse, and no further pulses while `cs_n` is held.
- Two-byte read:
  - Stimulus: send 8'h05; the bench model drives `data_out`=8'h3C combinationally when `byte_sync` is high, then holds it. Then send 8'h00.
  - Required: MISO during the second byte reads 8'h3C, sampled by the master on `sclk` rising edges.
- Aborted byte: send 5 bits of 8'hFF, then raise `cs_n`.
  - Required: no `byte_sync`, and `data_in` keeps its previous value.
  - Then send a new full frame with 8'h81. Required: `data_in`=8'h81 and `bit_cnt` restarted at 0.
- Reset mid-frame: assert `rst_n`=0 after bit 4, release, then send 8'h42 in a new frame. Required: one `byte_sync` with `data_in`=8'h42.
- Back-to-back bytes: send 8'h12, 8'h34, 8'hFE in one frame at the minimum legal `sclk`.
  - Required: three `byte_sync` pulses with `data_in` equal to 8'h12, 8'h34, 8'hFE in order.
  - Required: `bit_cnt` wraps cleanly between bytes.
